// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl -- instruction-fetch sequencing controller
//
// Issues requests to a variable-latency instruction memory over a req/ack
// handshake, advances the PC register, and presents fetched words to decode
// through a registered output stage backed by a one-entry skid buffer.
// Redirects squash every younger fetch; a request that is already in flight
// is drained (its data discarded) rather than abandoned. A sticky flag
// reports a memory that has kept a request waiting MAX_WAIT cycles.
//
// Parameters
//   MAX_WAIT    ack-wait cycles before fetch_err sets (1..1023)
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   run         permit new requests (outstanding ones always complete)
//   pc          current PC from the PC register
//   pc_en       PC register enable (combinational)
//   redirect    taken branch/jump resolved in decode, 1-cycle pulse
//   id_stall    decode cannot accept this cycle
//   imem_req    memory request (registered, stable until ack)
//   imem_addr   memory request address (registered)
//   imem_ack    1-cycle ack; imem_rdata valid this cycle
//   imem_rdata  instruction word from memory
//   if_valid    if_instr/if_pc valid to decode
//   if_instr    fetched instruction
//   if_pc       address of if_instr
//   fetch_err   sticky memory-timeout flag
// -----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [31:0] pc,
  output logic        pc_en,
  input  logic        redirect,
  input  logic        id_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE,   // nothing outstanding
    S_WAIT,   // request outstanding, result will be kept
    S_DRAIN,  // request outstanding, result will be discarded
    S_HOLD    // skid buffer full, no request outstanding
  } state_e;

  localparam logic [9:0] MAX_W = 10'(MAX_WAIT);

  state_e      state_q;
  logic        imem_req_q;
  logic [31:0] imem_addr_q;
  logic        if_valid_q;
  logic [31:0] if_instr_q;
  logic [31:0] if_pc_q;
  logic [31:0] skid_instr_q;  // skid is full exactly when state_q == S_HOLD
  logic [31:0] skid_pc_q;
  logic [9:0]  wait_cnt_q;
  logic [9:0]  wait_cnt_d;
  logic        fetch_err_q;

  logic out_free;  // output register can take a new word at this edge
  logic consume;   // decode takes the output register at this edge

  assign out_free = !if_valid_q || !id_stall;
  assign consume  = if_valid_q && !id_stall;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    wait_cnt_d = '0;
    if ((state_q == S_WAIT || state_q == S_DRAIN) && !imem_ack) begin
      // Saturate so a dead memory cannot wrap the counter back below MAX_W.
      wait_cnt_d = (wait_cnt_q == MAX_W) ? wait_cnt_q : wait_cnt_q + 10'd1;
    end
  end

  // The PC moves on a redirect (loads the target) or when a kept fetch
  // completes (pc+4). Held low while reset is asserted.
  always_comb begin
    pc_en = 1'b0;
    if (rst_n && (redirect || (state_q == S_WAIT && imem_ack))) begin
      pc_en = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below sees the pre-edge value and later "default then
  // override" assignments in the same block resolve in source order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= '0;
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      if_pc_q      <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      wait_cnt_q   <= '0;
      fetch_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      if (wait_cnt_d == MAX_W) begin
        fetch_err_q <= 1'b1;
      end

      // Output drains when decode takes it; refills below override this.
      if (consume) begin
        if_valid_q <= 1'b0;
      end

      if (redirect) begin
        // Squash everything younger than the branch. An in-flight request
        // must still finish, so it is tracked in DRAIN until its ack.
        if_valid_q <= 1'b0;
        case (state_q)
          S_WAIT, S_DRAIN: begin
            if (imem_ack) begin
              imem_req_q <= 1'b0;
              state_q    <= S_IDLE;
            end else begin
              state_q <= S_DRAIN;
            end
          end
          default: state_q <= S_IDLE;  // IDLE stays, HOLD drops its skid
        endcase
      end else begin
        case (state_q)
          S_IDLE: begin
            if (run) begin
              imem_req_q  <= 1'b1;
              imem_addr_q <= pc;
              state_q     <= S_WAIT;
            end
          end

          S_WAIT: begin
            if (imem_ack) begin
              if (out_free) begin
                if_instr_q <= imem_rdata;
                if_pc_q    <= imem_addr_q;
                if_valid_q <= 1'b1;
                if (run) begin
                  // Back-to-back: keep req high and run ahead of the PC
                  // register, which is advancing to the same address.
                  imem_addr_q <= imem_addr_q + 32'd4;
                end else begin
                  imem_req_q <= 1'b0;
                  state_q    <= S_IDLE;
                end
              end else begin
                // Output occupied and stalled: park the word and stop
                // requesting so nothing can overrun the skid.
                skid_instr_q <= imem_rdata;
                skid_pc_q    <= imem_addr_q;
                imem_req_q   <= 1'b0;
                state_q      <= S_HOLD;
              end
            end
          end

          S_DRAIN: begin
            if (imem_ack) begin
              imem_req_q <= 1'b0;
              state_q    <= S_IDLE;
            end
          end

          S_HOLD: begin
            if (consume) begin
              if_instr_q <= skid_instr_q;
              if_pc_q    <= skid_pc_q;
              if_valid_q <= 1'b1;
              state_q    <= S_IDLE;
            end
          end

          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl -- directed self-checking bench for fetch_ctrl
//
// Inputs change 1 time unit after a rising edge; registered outputs are
// compared there, and pc_en (combinational) is compared once inputs settle.
// The bench models the PC register so the DUT sees a realistic pc input.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

  localparam logic [31:0] I0 = 32'h1111_0000;
  localparam logic [31:0] I1 = 32'h2222_0004;
  localparam logic [31:0] I2 = 32'h3333_0008;
  localparam logic [31:0] I3 = 32'h4444_000C;
  localparam logic [31:0] I4 = 32'h5555_0010;
  localparam logic [31:0] I5 = 32'h6666_0200;
  localparam logic [31:0] I6 = 32'h7777_0204;
  localparam logic [31:0] I7 = 32'h8888_FFFC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [31:0] pc;
  logic        pc_en;
  logic        redirect;
  logic        id_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_err;

  logic [31:0] pc_rst_val = 32'h0040_0000;
  logic [31:0] tgt        = 32'h0;

  int vectors     = 0;
  int miscompares = 0;

  fetch_ctrl #(.MAX_WAIT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .pc         (pc),
    .pc_en      (pc_en),
    .redirect   (redirect),
    .id_stall   (id_stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  // PC register driven by pc_en: redirect loads the target, otherwise +4.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)     pc <= pc_rst_val;
    else if (pc_en) pc <= redirect ? tgt : pc + 32'd4;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; run = 1'b0; redirect = 1'b1; id_stall = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;

    // ---- reset values; pc_en gated even with redirect high ----
    #12;
    check("rst_req",   32'(imem_req),  32'd0);
    check("rst_addr",  imem_addr,      32'h0);
    check("rst_valid", 32'(if_valid),  32'd0);
    check("rst_instr", if_instr,       32'h0);
    check("rst_ifpc",  if_pc,          32'h0);
    check("rst_err",   32'(fetch_err), 32'd0);
    check("rst_pc_en", 32'(pc_en),     32'd0);
    redirect = 1'b0;
    run = 1'b1;
    #10 rst_n = 1'b1;

    // ---- reset and stream: 1-cycle ack, no stall ----
    tick();
    check("first_req",  32'(imem_req), 32'd1);
    check("first_addr", imem_addr,      32'h0040_0000);
    imem_ack = 1'b1; imem_rdata = I0; #1;
    check("s0_pc_en", 32'(pc_en), 32'd1);
    tick();
    check("s0_valid", 32'(if_valid), 32'd1);
    check("s0_ifpc",  if_pc,         32'h0040_0000);
    check("s0_instr", if_instr,      I0);
    check("s0_addr",  imem_addr,     32'h0040_0004);
    imem_rdata = I1; #1;
    check("s1_pc_en", 32'(pc_en), 32'd1);
    tick();
    check("s1_ifpc",  if_pc,    32'h0040_0004);
    check("s1_instr", if_instr, I1);
    imem_rdata = I2; #1;
    check("s2_pc_en", 32'(pc_en), 32'd1);
    tick();
    check("s2_ifpc",  if_pc,     32'h0040_0008);
    check("s2_instr", if_instr,  I2);
    check("s2_addr",  imem_addr, 32'h0040_000C);

    // ---- stall with skid: two acks inside a 4-cycle stall ----
    imem_ack = 1'b0;
    tick();                                   // I2 consumed, output empty
    check("k_empty", 32'(if_valid), 32'd0);
    id_stall = 1'b1; imem_ack = 1'b1; imem_rdata = I3;
    tick();                                   // I3 to output
    check("k_out_instr", if_instr, I3);
    check("k_out_addr",  imem_addr, 32'h0040_0010);
    imem_rdata = I4;
    tick();                                   // I4 to skid, HOLD
    imem_ack = 1'b0; #1;
    check("k_hold_req",   32'(imem_req), 32'd0);
    check("k_hold_instr", if_instr,      I3);
    check("k_hold_pc_en", 32'(pc_en),    32'd0);
    tick();
    tick();
    check("k_held_instr", if_instr,      I3);
    check("k_held_ifpc",  if_pc,         32'h0040_000C);
    check("k_held_valid", 32'(if_valid), 32'd1);
    check("k_held_req",   32'(imem_req), 32'd0);
    id_stall = 1'b0;
    tick();                                   // skid to output, IDLE
    check("k_skid_instr", if_instr,      I4);
    check("k_skid_ifpc",  if_pc,         32'h0040_0010);
    check("k_skid_valid", 32'(if_valid), 32'd1);
    check("k_skid_req",   32'(imem_req), 32'd0);
    tick();                                   // I4 consumed, new request
    check("k_after_valid", 32'(if_valid), 32'd0);
    check("k_after_req",   32'(imem_req), 32'd1);
    check("k_after_addr",  imem_addr,     32'h0040_0014);

    // ---- redirect one cycle after req, ack three cycles later ----
    redirect = 1'b1; tgt = 32'h0040_0100; #1;
    check("r_pc_en", 32'(pc_en), 32'd1);
    tick();
    redirect = 1'b0; #1;
    check("r_d1_pc_en", 32'(pc_en),    32'd0);
    check("r_d1_valid", 32'(if_valid), 32'd0);
    check("r_d1_req",   32'(imem_req), 32'd1);
    check("r_d1_addr",  imem_addr,     32'h0040_0014);
    check("r_pc_tgt",   pc,            32'h0040_0100);
    tick();
    check("r_d2_valid", 32'(if_valid), 32'd0);
    tick();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    check("r_ack_pc_en", 32'(pc_en), 32'd0);
    tick();
    imem_ack = 1'b0;
    check("r_drop_valid", 32'(if_valid), 32'd0);
    check("r_drop_req",   32'(imem_req), 32'd0);
    tick();
    check("r_new_req",  32'(imem_req), 32'd1);
    check("r_new_addr", imem_addr,     32'h0040_0100);

    // ---- redirect coincident with ack ----
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0100;
    redirect = 1'b1; tgt = 32'h0040_0200; #1;
    check("c_pc_en", 32'(pc_en), 32'd1);
    tick();
    imem_ack = 1'b0; redirect = 1'b0; #1;
    check("c_idle_req",   32'(imem_req), 32'd0);
    check("c_idle_valid", 32'(if_valid), 32'd0);
    check("c_single_pc_en", 32'(pc_en),  32'd0);
    tick();
    check("c_new_req",  32'(imem_req), 32'd1);
    check("c_new_addr", imem_addr,     32'h0040_0200);

    // ---- timeout: MAX_WAIT=8, ack withheld 20 cycles ----
    for (int i = 0; i < 7; i++) tick();
    check("t_err_7", 32'(fetch_err), 32'd0);
    tick();
    check("t_err_8", 32'(fetch_err), 32'd1);
    for (int i = 0; i < 12; i++) tick();
    check("t_req_up", 32'(imem_req), 32'd1);
    check("t_addr",   imem_addr,     32'h0040_0200);
    imem_ack = 1'b1; imem_rdata = I5;
    tick();
    check("t_done_instr", if_instr,       I5);
    check("t_done_ifpc",  if_pc,          32'h0040_0200);
    check("t_err_sticky", 32'(fetch_err), 32'd1);

    // ---- async reset mid-HOLD ----
    id_stall = 1'b1; imem_rdata = I6;
    tick();                                   // I5 held, I6 into skid
    imem_ack = 1'b0;
    check("h_req",   32'(imem_req), 32'd0);
    check("h_instr", if_instr,      I5);
    #2;
    pc_rst_val = 32'hFFFF_FFFC;
    rst_n = 1'b0;
    #1;
    check("a_req",   32'(imem_req),  32'd0);
    check("a_addr",  imem_addr,      32'h0);
    check("a_valid", 32'(if_valid),  32'd0);
    check("a_instr", if_instr,       32'h0);
    check("a_ifpc",  if_pc,          32'h0);
    check("a_err",   32'(fetch_err), 32'd0);
    check("a_pc_en", 32'(pc_en),     32'd0);

    // ---- address wrap at 0xFFFFFFFC ----
    id_stall = 1'b0;
    #3 rst_n = 1'b1;
    tick();
    check("w_addr", imem_addr, 32'hFFFF_FFFC);
    imem_ack = 1'b1; imem_rdata = I7;
    tick();
    imem_ack = 1'b0;
    check("w_ifpc",     if_pc,     32'hFFFF_FFFC);
    check("w_instr",    if_instr,  I7);
    check("w_next_addr", imem_addr, 32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
